// File: rtl/riscv_regfile_sb_pkg.sv
// riscv_regfile_sb_pkg: shared widths and the writeback record for the register file.
`default_nettype none

package riscv_regfile_sb_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_RPORTS = 2;
  localparam logic [RF_ADDR_WIDTH-1:0] RF_ZERO_ADDR = 5'd0;

  // Writeback record driven by the id2wb/ex2wb stages into the write port.
  typedef struct packed {
    logic                     we;
    logic [RF_ADDR_WIDTH-1:0] waddr;
    logic [RF_DATA_WIDTH-1:0] wdata;
  } rf_wb_t;

endpackage

`default_nettype wire

// File: rtl/riscv_scoreboard.sv
// +--------------------------------------------------------------------------+
// | riscv_scoreboard: per-register busy bits with flush > issue > wb priority |
// | Optional: REGFILE_BYPASS_EN. Rev 1.0                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module riscv_scoreboard
  import riscv_regfile_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     waddr_i,
  input  logic                      issue_i,
  input  logic [ADDR_WIDTH-1:0]     issue_addr_i,
  input  logic                      flush_i,
  output logic [2**ADDR_WIDTH-1:0]  busy_o,
  output logic                      issue_ready_o
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                w_dest_busy;

  always_comb begin
    w_dest_busy = busy_q[issue_addr_i];
`ifdef REGFILE_BYPASS_EN
    // A writeback retiring the destination this cycle frees it for a new producer.
    if (we_i && (waddr_i == issue_addr_i)) w_dest_busy = 1'b0;
`endif
    issue_ready_o = issue_i & ~w_dest_busy & ~flush_i;
  end

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (we_i)          busy_d[waddr_i]      = 1'b0;
      if (issue_ready_o) busy_d[issue_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/riscv_regfile_sb.sv
// +--------------------------------------------------------------------------+
// | riscv_regfile_sb: register file with combinational reads and scoreboard  |
// | Optional: REGFILE_BYPASS_EN (write-to-read forwarding). Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module riscv_regfile_sb
  import riscv_regfile_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_RPORTS = RF_NUM_RPORTS,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]            rbusy_o,
  input  logic                             we_i,
  input  logic [ADDR_WIDTH-1:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic                             issue_i,
  input  logic [ADDR_WIDTH-1:0]            issue_addr_i,
  output logic                             issue_ready_o,
  input  logic                             flush_i
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(RF_ZERO_ADDR);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy;
  logic                  w_wr_en;

  assign w_wr_en = we_i && !((ZERO_REG != 0) && (waddr_i == ZERO_ADDR));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (w_wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  riscv_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .issue_i       (issue_i),
    .issue_addr_i  (issue_addr_i),
    .flush_i       (flush_i),
    .busy_o        (w_busy),
    .issue_ready_o (issue_ready_o)
  );

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_is_zero;
    logic                  w_fwd;

    assign w_ra      = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_is_zero = (ZERO_REG != 0) && (w_ra == ZERO_ADDR);
`ifdef REGFILE_BYPASS_EN
    assign w_fwd = w_wr_en && (waddr_i == w_ra);
`else
    assign w_fwd = 1'b0;
`endif

    always_comb begin
      if (w_is_zero)  rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (w_fwd) rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata_i;
      else            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[w_ra];
      rbusy_o[p] = w_busy[w_ra] & ~w_fwd;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_regfile_sb.sv
// tb_riscv_regfile_sb: directed vector table, bypass corner sequence and random run
// against a behavioural register/busy model.
`default_nettype none

module tb_riscv_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_regfile_sb dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rbusy_o       (rbusy),
    .we_i          (we),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .issue_i       (issue),
    .issue_addr_i  (issue_addr),
    .issue_ready_o (issue_ready),
    .flush_i       (flush)
  );

  typedef struct {
    logic        rst, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [31:0] d0, d1;
    logic        b0, b1, rdy;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                              logic i, logic [4:0] ia, logic f,
                              logic [4:0] ra0, logic [4:0] ra1,
                              logic [31:0] d0, logic [31:0] d1,
                              logic b0, logic b1, logic rdy);
    vec_t v;
    v.rst = r; v.we = w; v.wa = wa; v.wd = wd; v.iss = i; v.ia = ia; v.fl = f;
    v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic i, input logic [4:0] ia, input logic f,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; we = w; waddr = wa; wdata = wd; issue = i; issue_addr = ia; flush = f;
    raddr = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model: architectural registers and pending-destination flags.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  initial begin
    logic [4:0]  ra [2];
    logic [31:0] exp_d;
    logic        exp_b, exp_rdy, fwd;

    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    do_reset();

    //          rst we wa     wd            iss ia    fl ra0   ra1    d0            d1            b0 b1 rdy
    tbl[0]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd5,  0, 5'd3,  5'd31, 32'h0,        32'h0,        0, 0, 1);
    tbl[1]  = mk(0, 1, 5'd7,  32'hDEADBEEF, 1, 5'd5,  0, 5'd5,  5'd5,  32'h0,        32'h0,        1, 1, 0);
    tbl[2]  = mk(0, 1, 5'd0,  32'h1234,     0, 5'd0,  0, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  0, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 0, 0, 1);
    tbl[4]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  0, 5'd9,  5'd9,  32'h0,        32'h0,        1, 1, 0);
    tbl[5]  = mk(0, 1, 5'd9,  32'h55,       0, 5'd0,  0, 5'd5,  5'd7,  32'h0,        32'hDEADBEEF, 1, 0, 0);
    tbl[6]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  0, 5'd9,  5'd0,  32'h55,       32'h0,        0, 0, 1);
    tbl[7]  = mk(0, 1, 5'd5,  32'h77,       1, 5'd2,  0, 5'd9,  5'd3,  32'h55,       32'h0,        1, 0, 1);
    tbl[8]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd5,  5'd2,  32'h77,       32'h0,        0, 1, 1);
    tbl[9]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd4,  0, 5'd3,  5'd4,  32'h0,        32'h0,        1, 0, 1);
    tbl[10] = mk(0, 0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd4,  5'd9,  32'h0,        32'h55,       1, 1, 0);
    tbl[11] = mk(0, 1, 5'd3,  32'h7,        0, 5'd0,  0, 5'd5,  5'd2,  32'h77,       32'h0,        0, 0, 0);
    tbl[12] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd3,  5'd4,  32'h7,        32'h0,        0, 0, 0);
    tbl[13] = mk(1, 0, 5'd0,  32'h0,        1, 5'd6,  0, 5'd7,  5'd6,  32'hDEADBEEF, 32'h0,        0, 0, 1);
    tbl[14] = mk(0, 0, 5'd0,  32'h0,        1, 5'd6,  0, 5'd6,  5'd7,  32'h0,        32'h0,        0, 0, 1);
    tbl[15] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  0, 5'd6,  5'd5,  32'h0,        32'h0,        1, 0, 0);

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].rst, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].iss, tbl[k].ia, tbl[k].fl,
            tbl[k].ra0, tbl[k].ra1);
      #3;
      chk($sformatf("vec%0d rdata0", k), rdata[31:0],  tbl[k].d0);
      chk($sformatf("vec%0d rdata1", k), rdata[63:32], tbl[k].d1);
      chk($sformatf("vec%0d rbusy0", k), {31'd0, rbusy[0]}, {31'd0, tbl[k].b0});
      chk($sformatf("vec%0d rbusy1", k), {31'd0, rbusy[1]}, {31'd0, tbl[k].b1});
      chk($sformatf("vec%0d ready",  k), {31'd0, issue_ready}, {31'd0, tbl[k].rdy});
      tick();
    end

    // Same-cycle writeback to a pending destination, read and re-issued at once.
    do_reset();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    tick();
    drive(1'b0, 1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    #3;
    chk("wb_same rdata0", rdata[31:0],  BYP ? 32'hAA : 32'h0);
    chk("wb_same rdata1", rdata[63:32], BYP ? 32'hAA : 32'h0);
    chk("wb_same rbusy",  {30'd0, rbusy}, BYP ? 32'd0 : 32'd3);
    chk("wb_same ready",  {31'd0, issue_ready}, {31'd0, BYP});
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
    #3;
    chk("wb_next rdata0", rdata[31:0], 32'hAA);
    // With forwarding the re-issue was accepted, so x9 has a new pending producer.
    chk("wb_next rbusy0", {31'd0, rbusy[0]}, {31'd0, BYP});
    tick();

    // Random traffic against the model.
    do_reset();
    model_clear();
    for (int n = 0; n < 2000; n++) begin
      logic        r_rst, r_we, r_iss, r_fl;
      logic [4:0]  r_wa, r_ia;
      logic [31:0] r_wd;
      r_rst = ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 29) == 0);
      r_we  = $urandom_range(0, 1);
      r_iss = $urandom_range(0, 1);
      r_wd  = $urandom;
      r_wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r_ia  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra[0] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra[1] = ($urandom_range(0, 2) == 0) ? ra[0] : 5'($urandom_range(0, 7));
      drive(r_rst, r_we, r_wa, r_wd, r_iss, r_ia, r_fl, ra[0], ra[1]);
      #3;
      for (int p = 0; p < 2; p++) begin
        fwd   = BYP && r_we && (r_wa == ra[p]) && (ra[p] != 5'd0);
        exp_d = (ra[p] == 5'd0) ? 32'd0 : (fwd ? r_wd : m_regs[ra[p]]);
        exp_b = fwd ? 1'b0 : m_busy[ra[p]];
        chk($sformatf("rnd%0d rdata%0d", n, p), rdata[p*32 +: 32], exp_d);
        chk($sformatf("rnd%0d rbusy%0d", n, p), {31'd0, rbusy[p]}, {31'd0, exp_b});
      end
      exp_rdy = r_iss && !r_fl &&
                (!m_busy[r_ia] || (BYP && r_we && (r_wa == r_ia)));
      chk($sformatf("rnd%0d ready", n), {31'd0, issue_ready}, {31'd0, exp_rdy});
      if (r_rst) begin
        model_clear();
      end else begin
        if (r_we && r_wa != 5'd0) m_regs[r_wa] = r_wd;
        if (r_fl) begin
          for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
          if (r_we) m_busy[r_wa] = 1'b0;
          if (exp_rdy && r_ia != 5'd0) m_busy[r_ia] = 1'b1;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
